// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, forwarding and stall control for a 5-stage MIPS pipeline
module pipe_hazard_ctrl #(
   parameter int          CNT_W  = 16,
   parameter logic [4:0]  RA_REG = 5'd31
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [2:0]       id_op,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic             ex_br_taken,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             pipe_freeze,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             illegal,
   output logic [CNT_W-1:0] stall_cnt
);

   // Each shadow stage keeps only the fields that later stages still consult.
   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
      logic       is_load;
      logic       is_mem;
      logic [4:0] src_a;
      logic       use_a;
      logic [4:0] src_b;
      logic       use_b;
   } ex_rec_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
      logic       is_load;
      logic       is_mem;
   } mem_rec_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
   } wb_rec_t;

   ex_rec_t  id_rec, ex_q;
   mem_rec_t mem_q;
   wb_rec_t  wb_q;
   logic     mem_wait, load_use, jal_id;

   always_comb begin
      id_rec       = '0;
      id_rec.valid = id_valid;
      id_rec.src_a = id_rs;
      id_rec.src_b = id_rt;
      case (id_op)
         3'd0, 3'd1: begin
            id_rec.dst   = id_rd;
            id_rec.use_a = 1'b1;
            id_rec.use_b = 1'b1;
         end
         3'd2: begin
            id_rec.dst   = id_rt;
            id_rec.use_a = 1'b1;
         end
         3'd3: begin
            id_rec.dst     = id_rt;
            id_rec.use_a   = 1'b1;
            id_rec.is_load = 1'b1;
            id_rec.is_mem  = 1'b1;
         end
         3'd4: begin
            id_rec.use_a  = 1'b1;
            id_rec.use_b  = 1'b1;
            id_rec.is_mem = 1'b1;
         end
         3'd5: begin
            id_rec.use_a = 1'b1;
            id_rec.use_b = 1'b1;
         end
         3'd6:    id_rec.dst = RA_REG;
         default: id_rec.dst = 5'd0;
      endcase
   end

   assign mem_wait = mem_q.valid && mem_q.is_mem && !mem_ready;
   assign load_use = id_valid && ex_q.valid && ex_q.is_load && (ex_q.dst != 5'd0) &&
                     ((id_rec.use_a && (id_rs == ex_q.dst)) ||
                      (id_rec.use_b && (id_rt == ex_q.dst)));
   assign jal_id   = id_valid && (id_op == 3'd6);

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_freeze = 1'b0;
      if (mem_wait) begin
         pipe_freeze = 1'b1;
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
      end else if (ex_br_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_bubble = 1'b1;
      end else if (jal_id) begin
         ifid_flush  = 1'b1;
      end
   end

   // A load sitting in MEM has no data yet, so it never feeds the EX/MEM path.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (ex_q.use_a && ex_q.src_a != 5'd0) begin
         if (mem_q.valid && !mem_q.is_load && mem_q.dst == ex_q.src_a) fwd_a = 2'b01;
         else if (wb_q.valid && wb_q.dst == ex_q.src_a)                 fwd_a = 2'b10;
      end
      if (ex_q.use_b && ex_q.src_b != 5'd0) begin
         if (mem_q.valid && !mem_q.is_load && mem_q.dst == ex_q.src_b) fwd_b = 2'b01;
         else if (wb_q.valid && wb_q.dst == ex_q.src_b)                 fwd_b = 2'b10;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q      <= '0;
         mem_q     <= '0;
         wb_q      <= '0;
         illegal   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (!pipe_freeze) begin
            wb_q  <= '{valid: mem_q.valid, dst: mem_q.dst};
            mem_q <= '{valid: ex_q.valid, dst: ex_q.dst, is_load: ex_q.is_load, is_mem: ex_q.is_mem};
            ex_q  <= (id_valid && !idex_bubble) ? id_rec : '0;
            if (id_valid && !idex_bubble && id_op == 3'd7)
               illegal <= 1'b1;
         end
         if (!pc_en && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

   localparam logic [2:0] OP_ADDU = 3'd0, OP_SUBU = 3'd1, OP_ORI = 3'd2, OP_LW = 3'd3,
                          OP_SW = 3'd4, OP_JAL = 3'd6, OP_UND = 3'd7;
   localparam logic [8:0] NOM = 9'b11000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0;
   logic [2:0]  id_op = 3'd0;
   logic [4:0]  id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
   logic        ex_br_taken = 1'b0;
   logic        mem_ready = 1'b1;
   logic        pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze, illegal;
   logic [1:0]  fwd_a, fwd_b;
   logic [15:0] stall_cnt;
   logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble, s_pipe_freeze, s_illegal;
   logic [1:0]  s_fwd_a, s_fwd_b;
   logic [2:0]  s_stall_cnt;
   logic [8:0]  ctl, exp;
   int          n_vec = 0;
   int          n_err = 0;

   assign ctl = {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_freeze, fwd_a, fwd_b};

   always #5 clk = ~clk;

   pipe_hazard_ctrl u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs),
      .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken), .mem_ready(mem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .pipe_freeze(pipe_freeze), .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal(illegal),
      .stall_cnt(stall_cnt)
   );

   pipe_hazard_ctrl #(.CNT_W(3)) u_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_rs(id_rs),
      .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken), .mem_ready(mem_ready),
      .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
      .idex_bubble(s_idex_bubble), .pipe_freeze(s_pipe_freeze), .fwd_a(s_fwd_a),
      .fwd_b(s_fwd_b), .illegal(s_illegal), .stall_cnt(s_stall_cnt)
   );

   task automatic drive(input logic v, input logic [2:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input logic br, input logic mr);
      @(negedge clk);
      id_valid = v; id_op = op; id_rs = rs; id_rt = rt; id_rd = rd;
      ex_br_taken = br; mem_ready = mr;
      #1;
   endtask

   task automatic nop();
      drive(1'b0, OP_ADDU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; id_valid = 1'b0; ex_br_taken = 1'b0; mem_ready = 1'b1;
      #1;
      n_vec++;
      if (ctl !== NOM || stall_cnt !== 16'd0 || illegal !== 1'b0) begin
         n_err++;
         $display("FAIL reset: ctl=%b cnt=%0d ill=%b, expected ctl=%b cnt=0 ill=0",
                  ctl, stall_cnt, illegal, NOM);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      test_reset();
      drive(1'b1, OP_ADDU, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
      drive(1'b1, OP_SUBU, 5'd3, 5'd3, 5'd4, 1'b0, 1'b1);
      n_vec++;
      if (ctl !== NOM) begin
         n_err++; $display("FAIL b2b_issue: ctl=%b expected %b", ctl, NOM);
      end
      nop();
      exp = 9'b11000_0101;
      n_vec++;
      if (ctl !== exp || stall_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL b2b_fwd: ctl=%b cnt=%0d expected ctl=%b cnt=0", ctl, stall_cnt, exp);
      end
   endtask

   task automatic test_distance2();
      test_reset();
      drive(1'b1, OP_ORI, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1);
      nop();
      drive(1'b1, OP_ADDU, 5'd5, 5'd0, 5'd6, 1'b0, 1'b1);
      nop();
      exp = 9'b11000_1000;
      n_vec++;
      if (ctl !== exp) begin
         n_err++; $display("FAIL dist2_wb: ctl=%b expected %b", ctl, exp);
      end
      test_reset();
      drive(1'b1, OP_ORI, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1);
      drive(1'b1, OP_ADDU, 5'd1, 5'd1, 5'd5, 1'b0, 1'b1);
      drive(1'b1, OP_ADDU, 5'd5, 5'd0, 5'd6, 1'b0, 1'b1);
      nop();
      exp = 9'b11000_0100;
      n_vec++;
      if (ctl !== exp) begin
         n_err++; $display("FAIL dist2_mem_over_wb: ctl=%b expected %b", ctl, exp);
      end
   endtask

   task automatic test_load_use();
      test_reset();
      drive(1'b1, OP_LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
      drive(1'b1, OP_ADDU, 5'd2, 5'd2, 5'd3, 1'b0, 1'b1);
      exp = 9'b00010_0000;
      n_vec++;
      if (ctl !== exp) begin
         n_err++; $display("FAIL lu_stall: ctl=%b expected %b", ctl, exp);
      end
      drive(1'b1, OP_ADDU, 5'd2, 5'd2, 5'd3, 1'b0, 1'b1);
      n_vec++;
      if (ctl !== NOM) begin
         n_err++; $display("FAIL lu_single_bubble: ctl=%b expected %b", ctl, NOM);
      end
      nop();
      exp = 9'b11000_1010;
      n_vec++;
      if (ctl !== exp || stall_cnt !== 16'd1) begin
         n_err++;
         $display("FAIL lu_fwd: ctl=%b cnt=%0d expected ctl=%b cnt=1", ctl, stall_cnt, exp);
      end
      test_reset();
      drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd0, 1'b0, 1'b1);
      drive(1'b1, OP_ADDU, 5'd0, 5'd0, 5'd3, 1'b0, 1'b1);
      n_vec++;
      if (ctl !== NOM) begin
         n_err++; $display("FAIL lu_reg0: ctl=%b expected %b", ctl, NOM);
      end
   endtask

   task automatic test_branch();
      test_reset();
      drive(1'b1, OP_LW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
      drive(1'b1, OP_ADDU, 5'd2, 5'd2, 5'd3, 1'b1, 1'b1);
      exp = 9'b11110_0000;
      n_vec++;
      if (ctl !== exp) begin
         n_err++; $display("FAIL br_over_lu: ctl=%b expected %b", ctl, exp);
      end
      nop();
      n_vec++;
      if (stall_cnt !== 16'd0) begin
         n_err++; $display("FAIL br_no_stall_cnt: cnt=%0d expected 0", stall_cnt);
      end
      test_reset();
      drive(1'b1, OP_JAL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
      exp = 9'b11100_0000;
      n_vec++;
      if (ctl !== exp) begin
         n_err++; $display("FAIL jal_flush: ctl=%b expected %b", ctl, exp);
      end
   endtask

   task automatic test_mem_wait();
      test_reset();
      drive(1'b1, OP_ADDU, 5'd7, 5'd7, 5'd1, 1'b0, 1'b1);
      drive(1'b1, OP_SW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
      drive(1'b1, OP_ADDU, 5'd1, 5'd0, 5'd9, 1'b0, 1'b1);
      exp = 9'b11000_0100;
      n_vec++;
      if (ctl !== exp) begin
         n_err++; $display("FAIL mw_sw_fwd: ctl=%b expected %b", ctl, exp);
      end
      exp = 9'b00001_1000;
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, OP_ADDU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
         n_vec++;
         if (ctl !== exp) begin
            n_err++; $display("FAIL mw_freeze[%0d]: ctl=%b expected %b", i, ctl, exp);
         end
         if (i == 3) begin
            n_vec++;
            if (stall_cnt !== 16'd3) begin
               n_err++; $display("FAIL mw_cnt3: cnt=%0d expected 3", stall_cnt);
            end
         end
      end
      nop();
      exp = 9'b11000_1000;
      n_vec++;
      if (ctl !== exp || stall_cnt !== 16'd10 || s_stall_cnt !== 3'd7) begin
         n_err++;
         $display("FAIL mw_release: ctl=%b cnt=%0d sat=%0d expected ctl=%b cnt=10 sat=7",
                  ctl, stall_cnt, s_stall_cnt, exp);
      end
   endtask

   task automatic test_async_reset();
      test_reset();
      drive(1'b1, OP_SW, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1);
      nop();
      drive(1'b0, OP_ADDU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      n_vec++;
      if (pipe_freeze !== 1'b1 || pc_en !== 1'b0) begin
         n_err++;
         $display("FAIL ar_freeze: freeze=%b pc_en=%b expected 1 0", pipe_freeze, pc_en);
      end
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if (ctl !== NOM || stall_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL ar_async: ctl=%b cnt=%0d expected ctl=%b cnt=0", ctl, stall_cnt, NOM);
      end
      @(negedge clk);
      mem_ready = 1'b1;
      rst_n = 1'b1;
   endtask

   task automatic test_illegal();
      test_reset();
      drive(1'b1, OP_UND, 5'd3, 5'd4, 5'd5, 1'b0, 1'b1);
      n_vec++;
      if (illegal !== 1'b0 || ctl !== NOM) begin
         n_err++;
         $display("FAIL ill_pre: ill=%b ctl=%b expected 0 %b", illegal, ctl, NOM);
      end
      for (int i = 0; i < 3; i++) begin
         nop();
         n_vec++;
         if (illegal !== 1'b1) begin
            n_err++; $display("FAIL ill_sticky[%0d]: ill=%b expected 1", i, illegal);
         end
      end
      test_reset();
      n_vec++;
      if (illegal !== 1'b0) begin
         n_err++; $display("FAIL ill_clear: ill=%b expected 0", illegal);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_distance2();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_async_reset();
      test_illegal();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Consumes decoded fields of the ID-stage instruction, using the decoder op encoding: 0 addu, 1 subu, 2 ori, 3 lw, 4 sw, 5 beq, 6 jal, 7 undefined.
- Keeps a shadow record of in-flight instructions and issues stage enables, bubble/flush controls and EX-operand forwarding selects.
- Also handles memory wait states and keeps a saturating stall-cycle counter.

Parameters:
- CNT_W, 16, width of the stall-cycle performance counter.
- RA_REG, 31, destination register written by jal.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_op  in  3  decoded op of the ID instruction.
- id_rs  in  5  rs field of the ID instruction.
- id_rt  in  5  rt field of the ID instruction.
- id_rd  in  5  rd field of the ID instruction.
- ex_br_taken  in  1  beq currently in EX resolved taken.
- mem_ready  in  1  data memory finished the current MEM access.
- pc_en  out  1  PC register write enable.
- ifid_en  out  1  IF/ID register write enable.
- ifid_flush  out  1  load a nop into IF/ID at the next edge.
- idex_bubble  out  1  load a nop into ID/EX at the next edge.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- fwd_a  out  2  EX operand A source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- fwd_b  out  2  EX operand B source, same encoding as fwd_a.
- illegal  out  1  sticky flag: an undefined op entered EX.
- stall_cnt  out  CNT_W  count of cycles with pc_en=0, saturating.

Behaviour:
- Destination rules:
  - addu/subu write rd.
  - ori/lw write rt.
  - jal writes RA_REG.
  - sw/beq/und write nothing.
  - A destination of 0 is treated as no destination.
- Source rules:
  - addu/subu/beq/sw read rs and rt.
  - ori/lw read rs only.
  - jal/und read nothing.
- Shadow pipeline: registers EX, MEM and WB, each holding valid, dst(5), is_load, is_mem, src_a(5), use_a, src_b(5), use_b.
  - Advances every cycle unless pipe_freeze=1.
  - EX receives the ID record, or an invalid record when idex_bubble=1 or id_valid=0.
- Reset: all shadow valid bits=0, illegal=0, stall_cnt=0.
  - Outputs after reset: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0, fwd_a=fwd_b=00.
- Control outputs are combinational from the shadow state and ID inputs. Priority, highest first:
  1. Memory freeze: MEM valid and is_mem and mem_ready=0.
     - pipe_freeze=1, pc_en=0, ifid_en=0, no flush, no bubble.
     - No other condition acts in that cycle.
  2. Taken branch: ex_br_taken=1.
     - ifid_flush=1 and idex_bubble=1, killing the two younger instructions.
     - pc_en=1, so the branch target is loaded.
     - Any load-use or jal condition in ID is ignored.
  3. Load-use: EX valid and is_load and EX.dst is nonzero and equals an ID source in use.
     - pc_en=0, ifid_en=0, idex_bubble=1.
     - Exactly one bubble per load; no second stall, because the value is forwarded from MEM/WB the next cycle.
  4. jal in ID, valid: ifid_flush=1 (one slot killed), pc_en=1.
- Forwarding for the EX record, per operand in use with a nonzero source:
  - 01 if MEM is valid, MEM.dst matches and MEM is not a load.
  - Otherwise 10 if WB is valid and WB.dst matches.
  - Otherwise 00.
  - MEM takes priority over WB when both match.
  - A load in MEM never forwards 01; load-use stalling guarantees this case does not arise.
- illegal: set when a valid record with op 7 enters EX. Cleared only by reset. The record is otherwise treated as a nop.
- stall_cnt: increments on every cycle with pc_en=0 and holds at all-ones.
- Reset asserted mid-freeze or mid-stall: everything returns to reset values immediately, asynchronously.

Test Plan:
- Back-to-back ALU forwarding: addu $3,$1,$2 then subu $4,$3,$3 -> in subu's EX cycle fwd_a=fwd_b=01, no stall, stall_cnt=0.
- Distance-2 forwarding: ori $5,$0,7; nop; addu $6,$5,$0 -> fwd_a=10 in addu's EX cycle; and with addu $5 issued in between, fwd_a=01, showing MEM beats WB.
- Load-use: lw $2,0($1) then addu $3,$2,$2 -> exactly one cycle of pc_en=0 and idex_bubble=1, then fwd_a=fwd_b=10; stall_cnt=1. Also: a load to $0 followed by a reader of $0 -> no stall.
- Branch vs load-use: ex_br_taken=1 in the same cycle an ID load-use exists -> ifid_flush=1, idex_bubble=1, pc_en=1. Also: jal alone -> ifid_flush=1 only.
- Memory wait: sw in MEM with mem_ready=0 for 3 cycles -> pipe_freeze=1 and pc_en=0 for 3 cycles, and forwarding selects are stable throughout; stall_cnt+=3; stall_cnt saturates at 0xFFFF.
- Async reset and illegal op: pulse rst_n low mid-freeze -> outputs at reset values before the next edge. Separately, an op 7 reaching EX -> illegal=1 stays high until reset.
